// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding,
// bus-facing field widths and default sizing.
package bus_pkg;

  localparam int STATE_W         = 4;
  localparam int MID_W           = 4;
  localparam int DEF_N_MASTERS   = 12;
  localparam int DEF_N_SLAVES    = 6;
  localparam int DEF_SID_WIDTH   = 3;
  localparam int DEF_TIMEOUT_LEN = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_GRANT   = 4'd1,
    ST_ADDR    = 4'd2,
    ST_CHECK   = 4'd3,
    ST_CONNECT = 4'd4,
    ST_RELEASE = 4'd5
  } state_t;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Master/slave-facing bundle of the arbiter: requests, grants, serial slave ID,
// slave busy/select lines and status pulses.
interface bus_arbiter_rr_if
  import bus_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int N_SLAVES  = DEF_N_SLAVES
) ();

  logic [N_MASTERS-1:0] m_reqs;
  logic                 rr_mode;
  logic                 bus_util;
  logic                 b_bus;
  logic [N_SLAVES-1:0]  slave_busy;
  logic [N_MASTERS-1:0] m_grants;
  logic [N_SLAVES-1:0]  slv_sel;
  logic [MID_W-1:0]     mid_current;
  logic [STATE_W-1:0]   state;
  logic                 nack;
  logic                 timeout;

  // Arbiter side.
  modport slave (
    input  m_reqs, rr_mode, bus_util, b_bus, slave_busy,
    output m_grants, slv_sel, mid_current, state, nack, timeout
  );

  // Requesting masters and slaves, as seen from outside the arbiter.
  modport master (
    output m_reqs, rr_mode, bus_util, b_bus, slave_busy,
    input  m_grants, slv_sel, mid_current, state, nack, timeout
  );

endinterface

// File: rtl/arb_rr_picker.sv
// Combinational winner search: round-robin upward from last+1, or lowest index
// when rr_mode is 0.
module arb_rr_picker
  import bus_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS
) (
  input  logic [N_MASTERS-1:0] reqs,
  input  logic [MID_W-1:0]     last,
  input  logic                 rr_mode,
  output logic [N_MASTERS-1:0] onehot,
  output logic [MID_W-1:0]     index
);

  logic             found;
  logic [MID_W-1:0] cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = rr_mode ? MID_W'((int'(last) + 1 + k) % N_MASTERS) : MID_W'(k);
      if (!found && reqs[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
    if (found) begin
      onehot[index] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Bus arbiter: grants one master, receives a serial slave ID, connects a free
// slave or refuses with nack, and times out masters that never take the bus.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int N_MASTERS   = DEF_N_MASTERS,
  parameter int N_SLAVES    = DEF_N_SLAVES,
  parameter int SID_WIDTH   = DEF_SID_WIDTH,
  parameter int TIMEOUT_LEN = DEF_TIMEOUT_LEN
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_rr_if.slave bus
);

  localparam int BIT_W = $clog2(SID_WIDTH) + 1;

  state_t               state_reg;
  logic [N_MASTERS-1:0] grant_reg;
  logic [N_SLAVES-1:0]  sel_reg;
  logic [MID_W-1:0]     mid_reg;
  logic [MID_W-1:0]     winner_reg;
  logic [MID_W-1:0]     last_reg;
  logic [SID_WIDTH-1:0] sid_reg;
  logic [BIT_W-1:0]     bit_reg;
  logic [TIMEOUT_LEN-1:0] cnt_reg;
  logic                 nack_reg;
  logic                 timeout_reg;

  logic [N_MASTERS-1:0] pick_onehot;
  logic [MID_W-1:0]     pick_index;
  logic [N_SLAVES-1:0]  slave_hit;

  arb_rr_picker #(
    .N_MASTERS (N_MASTERS)
  ) u_picker (
    .reqs    (bus.m_reqs),
    .last    (last_reg),
    .rr_mode (bus.rr_mode),
    .onehot  (pick_onehot),
    .index   (pick_index)
  );

  // At most one bit can be set: the addressed slave, and only if it is free.
  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      assign slave_hit[gi] = (int'(sid_reg) == gi) && !bus.slave_busy[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      sel_reg     <= '0;
      mid_reg     <= '0;
      winner_reg  <= '0;
      last_reg    <= MID_W'(N_MASTERS - 1);
      sid_reg     <= '0;
      bit_reg     <= '0;
      cnt_reg     <= '0;
      nack_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      nack_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|bus.m_reqs) begin
            grant_reg  <= pick_onehot;
            mid_reg    <= pick_index;
            winner_reg <= pick_index;
            cnt_reg    <= '0;
            state_reg  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!bus.bus_util) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= ST_ADDR;
          end else if (!bus.m_reqs[winner_reg]) begin
            grant_reg <= '0;
            mid_reg   <= '0;
            state_reg <= ST_RELEASE;
          end else if (cnt_reg == '1) begin
            timeout_reg <= 1'b1;
            grant_reg   <= '0;
            mid_reg     <= '0;
            state_reg   <= ST_RELEASE;
          end else begin
            cnt_reg <= cnt_reg + TIMEOUT_LEN'(1);
          end
        end
        ST_ADDR: begin
          sid_reg <= {sid_reg[SID_WIDTH-2:0], bus.b_bus};
          bit_reg <= bit_reg + BIT_W'(1);
          if (bit_reg == BIT_W'(SID_WIDTH - 1)) begin
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (|slave_hit) begin
            sel_reg   <= slave_hit;
            state_reg <= ST_CONNECT;
          end else begin
            nack_reg  <= 1'b1;
            grant_reg <= '0;
            mid_reg   <= '0;
            state_reg <= ST_RELEASE;
          end
        end
        ST_CONNECT: begin
          if (bus.bus_util) begin
            grant_reg <= '0;
            sel_reg   <= '0;
            mid_reg   <= '0;
            state_reg <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          grant_reg <= '0;
          sel_reg   <= '0;
          mid_reg   <= '0;
          last_reg  <= winner_reg;
          state_reg <= ST_IDLE;
        end
        default: begin
          grant_reg <= '0;
          sel_reg   <= '0;
          mid_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_grants    = grant_reg;
  assign bus.slv_sel     = sel_reg;
  assign bus.mid_current = mid_reg;
  assign bus.state       = state_reg;
  assign bus.nack        = nack_reg;
  assign bus.timeout     = timeout_reg;

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter N_MASTERS, default 12, the number of master request/grant channels (2..16).
REQ-002 The block SHALL have parameter N_SLAVES, default 6, the number of slave select/busy channels (1..8).
REQ-003 The block SHALL have parameter SID_WIDTH, default 3, the serial slave-ID length in bits.
REQ-004 The block SHALL have parameter TIMEOUT_LEN, default 6, the grant-timeout counter width; the limit is 2^TIMEOUT_LEN clocks.
REQ-005 The block SHALL use one clock and an asynchronous active-high reset: clk  in  1  rising-edge system clock.
REQ-006 rst  in  1  async active-high reset.
REQ-007 m_reqs  in  N_MASTERS  per-master bus request, level.
REQ-008 rr_mode  in  1  1 = round-robin, 0 = fixed priority (lowest index wins); sampled only in IDLE.
REQ-009 bus_util  in  1  active-low bus-utilising line; 0 = the granted master is driving.
REQ-010 b_bus  in  1  serial bus; carries the slave ID, MSB first.
REQ-011 slave_busy  in  N_SLAVES  per-slave busy flag.
REQ-012 m_grants  out  N_MASTERS  one-hot grant.
REQ-013 slv_sel  out  N_SLAVES  one-hot slave connect.
REQ-014 mid_current  out  4  index of the granted master, 0 when idle.
REQ-015 state  out  4  FSM state code.
REQ-016 nack  out  1  one-cycle pulse on a slave refusal.
REQ-017 timeout  out  1  one-cycle pulse on a grant timeout.

Function
REQ-018 The FSM SHALL have states IDLE=0, GRANT=1, ADDR=2, CHECK=3, CONNECT=4, RELEASE=5; codes 6..15 SHALL return to IDLE.
REQ-019 IDLE: when any m_reqs bit is 1, the block SHALL select a winner, register it, and assert its m_grants bit on the next cycle (1-cycle latency) while entering GRANT.
REQ-020 Round-robin winner SHALL be the first requester found searching upward from (last_granted+1) mod N_MASTERS; fixed-priority winner SHALL be the lowest requesting index.
REQ-021 GRANT: bus_util sampled 0 SHALL move the FSM to ADDR and clear the timeout counter.
REQ-022 GRANT: if the winner's m_reqs bit drops first, the FSM SHALL go to RELEASE with no pulse.
REQ-023 GRANT: if the counter reaches 2^TIMEOUT_LEN-1, the block SHALL pulse timeout and go to RELEASE.
REQ-024 ADDR: the block SHALL shift b_bus into a SID_WIDTH register for exactly SID_WIDTH consecutive cycles, starting the cycle after bus_util was first seen low, then go to CHECK.
REQ-025 CHECK (1 cycle): if sid < N_SLAVES and slave_busy[sid]==0, slv_sel[sid] SHALL assert from the next cycle and the FSM SHALL enter CONNECT.
REQ-026 CHECK: otherwise (slave busy or out of range) the block SHALL pulse nack and go to RELEASE.
REQ-027 CONNECT: m_grants and slv_sel SHALL stay constant; the m_reqs level SHALL be ignored; exit to RELEASE SHALL occur when bus_util is sampled 1.
REQ-028 RELEASE (1 cycle): m_grants, slv_sel and mid_current SHALL be 0; last_granted SHALL update to the served master, including after nack or timeout; the next state SHALL be IDLE.
REQ-029 A master that drops its request and then re-requests SHALL NOT pre-empt; at most one grant and one slv_sel bit SHALL ever be high.
REQ-030 Requests arriving outside IDLE SHALL wait; simultaneous requests SHALL be resolved only by REQ-020.
REQ-031 m_grants, slv_sel, nack, timeout and mid_current SHALL be registered outputs.

Reset
REQ-032 When rst=1, all outputs SHALL be 0 immediately: state=IDLE, last_granted=N_MASTERS-1 (so master 0 wins first in RR), and the sid register and counter SHALL be 0.
REQ-033 Reset asserted mid-transaction SHALL drop grant and slv_sel without generating a nack or timeout pulse; after rst falls, the first arbitration SHALL occur on the first clk edge.

Structure
REQ-034 State codes, the state width (4) and default parameter values SHALL live in package bus_pkg.
REQ-035 Winner selection SHALL be a combinational sub-module arb_rr_picker(reqs, last, rr_mode -> onehot, index).

Verification
REQ-036 rr_mode=1, m_reqs bits 3, 4 and 5 held high, each transaction addressing a free slave 3 -> grants in order 3,4,5,3; mid_current follows 3,4,5,3.
REQ-037 rr_mode=0 with the same stimulus -> master 3 is granted on every arbitration; 4 and 5 are never granted.
REQ-038 Master 4 granted, bus_util held 1 for 64 cycles (TIMEOUT_LEN=6) -> timeout pulses on the 64th GRANT cycle; m_grants[4] is 0 by the cycle after RELEASE.
REQ-039 SID=3'b100 with slave_busy[4]=1 -> one nack pulse and slv_sel stays 0; SID=3'b111 with N_SLAVES=6 -> nack.
REQ-040 SID=3'b101 with slave 5 free -> slv_sel=6'b100000 is held until bus_util returns 1; then 0 through RELEASE.
REQ-041 rst asserted during CONNECT -> m_grants and slv_sel go 0 before the next clk edge, with no nack; after release of rst, a pending request is granted within 1 cycle.
